kbd_decode: RTL
===============

Name: kbd_decode

Overview:
- Downstream consumer of the PS/2 keyboard byte receiver. Pops raw scan-code-set-2 bytes through the receiver's rdy/done/dout handshake.
- Folds the prefix bytes (E0, F0, E1 pause sequence) into single key events and tracks modifier and Caps Lock state.
- Presents one event at a time to the CPU-side I/O register through the same rdy/done handshake style.

Parameters:
- PAUSE_SKIP, 7, number of bytes discarded after an E1 prefix (standard Pause sequence length minus one).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (rst=0 resets on the rising clk edge).
- sc_rdy  in  1  receiver holds a byte.
- sc_data  in  8  byte at the receiver FIFO head.
- sc_done  out  1  combinational; pops sc_data in this cycle.
- ev_rdy  out  1  an event is held in the output register.
- ev_code  out  8  scan code of the event (prefixes stripped).
- ev_brk  out  1  1 = key release, 0 = press.
- ev_ext  out  1  1 = E0-prefixed key or Pause.
- ev_done  in  1  consumer has read the event; honoured only while ev_rdy=1.
- mods  out  8  held modifiers: [0]LShift 12, [1]RShift 59, [2]LCtrl 14, [3]RCtrl E0 14, [4]LAlt 11, [5]RAlt E0 11, [6]LGui E0 1F, [7]RGui E0 27.
- caps  out  1  Caps Lock toggle state.
- err  out  1  one-cycle pulse when the keyboard error byte 00 or FF is received.

Behaviour:
- Reset values: ev_rdy=0, ev_code=0, ev_brk=0, ev_ext=0, mods=0, caps=0, err=0, caps_held=0, FSM=IDLE, skip counter=0. Reset mid-sequence discards any partial prefix.
- Accept condition: sc_done = sc_rdy & (~ev_rdy | ev_done). The byte is consumed on the same edge. A prefix byte also stalls while the output is full; this is deliberate and keeps the FIFO the only buffer.
- Output register:
  - Set on the edge that consumes a final byte.
  - Cleared on ev_rdy & ev_done unless reloaded on the same edge; a reload wins.
  - Latency: final byte popped in cycle N, so ev_rdy=1 in cycle N+1.
- FSM states: IDLE, EXT (after E0), BRK (after F0), EXTBRK (after E0 F0), SKIP (inside the pause sequence).
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> SKIP with counter=PAUSE_SKIP.
    - 00/FF -> err pulse, stay in IDLE.
    - AA/FA/FE/EE (BAT, ack, resend, echo) -> dropped, no event.
    - Any other byte -> make event {ext=0, brk=0}, stay in IDLE.
  - EXT:
    - F0 -> EXTBRK.
    - 12 or 59 (fake shift) -> dropped, back to IDLE.
    - 00/FF -> err pulse, back to IDLE.
    - Any other byte -> event {ext=1, brk=0}, back to IDLE.
  - BRK: 00/FF -> err pulse, back to IDLE; any other byte -> event {ext=0, brk=1}, back to IDLE.
  - EXTBRK: 12 or 59 -> dropped; otherwise event {ext=1, brk=1}. Back to IDLE in both cases.
  - SKIP:
    - Each popped byte decrements the counter.
    - The byte that takes the counter from 1 to 0 emits {code=77, ext=1, brk=0} and returns to IDLE.
    - No Pause break event exists.
- Modifiers: the matching mods bit is set on make and cleared on break, on the same edge the event is latched. Repeated makes leave the bit at 1.
- Caps Lock (code 58, non-ext):
  - Make with caps_held=0 toggles caps and sets caps_held.
  - Typematic repeat makes do not toggle.
  - Break clears caps_held.
  - Events are emitted for all of these.
- err: a single-cycle pulse, independent of the handshake; no event is produced.

Decomposition:
- Shared package kbd_pkg holds:
  - Prefix and special byte constants: E0, F0, E1, AA, FA, FE, EE, 00, FF.
  - Modifier codes and mods bit indices.
  - CAPS code 58 and PAUSE code 77.
  - FSM state encoding.
- No sub-module; the FSM, output register, and modifier logic fit in one module.

Test Plan:
- Byte 1C with ev_done tied 0 -> sc_done=1 for one cycle; next cycle ev_rdy=1, code=1C, brk=0, ext=0. A following byte 32 is not popped (sc_done=0) until ev_done=1.
- Bytes F0, 1C -> one event: code=1C, brk=1, ext=0. The F0 byte alone produces no ev_rdy.
- Bytes E0, 12, E0, 75 -> single event: code=75, ext=1, brk=0; the fake shift is dropped; mods stay 00.
- Bytes 12, E0 14, F0 12 -> mods=01, then 09, then 08; three events.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event: code=77, ext=1, brk=0. Then 58, 58, F0 58, 58 -> caps=1, stays 1, then toggles to 0.
- Byte FF -> err high for exactly one cycle, no event. Bytes E0, then rst=0 for one cycle, then 1C -> event code=1C, ext=0.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared constants for the PS/2 scan-code-set-2 event decoder.
// Prefix/special bytes, modifier codes, mods bit indices and FSM encoding.
package kbd_pkg;

  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_BRK       = 8'hF0;
  localparam logic [7:0] SC_PAUSE_PFX = 8'hE1;
  localparam logic [7:0] SC_BAT       = 8'hAA;
  localparam logic [7:0] SC_ACK       = 8'hFA;
  localparam logic [7:0] SC_RESEND    = 8'hFE;
  localparam logic [7:0] SC_ECHO      = 8'hEE;
  localparam logic [7:0] SC_ERR0      = 8'h00;
  localparam logic [7:0] SC_ERR1      = 8'hFF;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_LGUI   = 8'h1F;
  localparam logic [7:0] SC_RGUI   = 8'h27;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_PAUSE  = 8'h77;

  localparam int MOD_LSHIFT = 0;
  localparam int MOD_RSHIFT = 1;
  localparam int MOD_LCTRL  = 2;
  localparam int MOD_RCTRL  = 3;
  localparam int MOD_LALT   = 4;
  localparam int MOD_RALT   = 5;
  localparam int MOD_LGUI   = 6;
  localparam int MOD_RGUI   = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_SKIP
  } state_t;

  // One-hot mods bit touched by a key event, zero for non-modifier keys.
  function automatic logic [7:0] mod_mask(input logic [7:0] code, input logic ext);
    logic [7:0] m;
    m = '0;
    if (!ext) begin
      if (code == SC_LSHIFT) m[MOD_LSHIFT] = 1'b1;
      if (code == SC_RSHIFT) m[MOD_RSHIFT] = 1'b1;
      if (code == SC_CTRL)   m[MOD_LCTRL]  = 1'b1;
      if (code == SC_ALT)    m[MOD_LALT]   = 1'b1;
    end else begin
      if (code == SC_CTRL)   m[MOD_RCTRL]  = 1'b1;
      if (code == SC_ALT)    m[MOD_RALT]   = 1'b1;
      if (code == SC_LGUI)   m[MOD_LGUI]   = 1'b1;
      if (code == SC_RGUI)   m[MOD_RGUI]   = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/kbd_decode_if.sv
// Byte-in / event-out handshake bundle of the keyboard decoder.
// slave = decoder side, master = receiver/CPU side.
interface kbd_decode_if;
  logic       sc_rdy;
  logic [7:0] sc_data;
  logic       sc_done;
  logic       ev_rdy;
  logic [7:0] ev_code;
  logic       ev_brk;
  logic       ev_ext;
  logic       ev_done;
  logic [7:0] mods;
  logic       caps;
  logic       err;

  modport slave (
    input  sc_rdy, sc_data, ev_done,
    output sc_done, ev_rdy, ev_code, ev_brk, ev_ext, mods, caps, err
  );

  modport master (
    output sc_rdy, sc_data, ev_done,
    input  sc_done, ev_rdy, ev_code, ev_brk, ev_ext, mods, caps, err
  );
endinterface

// File: rtl/kbd_decode.sv
// Folds scan-code-set-2 prefix bytes into single key events, tracking
// modifier and Caps Lock state; one-deep event register toward the CPU.
module kbd_decode
  import kbd_pkg::*;
#(
  parameter int PAUSE_SKIP = 7
) (
  input  logic         clk,
  input  logic         rst,
  kbd_decode_if.slave  bus
);

  localparam int CW = $clog2(PAUSE_SKIP + 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_ev_rdy, r_ev_brk, r_ev_ext;
  logic [7:0]    r_ev_code, r_mods;
  logic          r_caps, r_caps_held, r_err;

  logic          w_accept, w_emit, w_err, w_ext, w_brk;
  logic          w_is_err, w_fake, w_drop;
  logic [7:0]    w_code, w_mask;

  // Prefix bytes stall too while the output is full, so the FIFO is the only buffer.
  assign w_accept = bus.sc_rdy & (~r_ev_rdy | bus.ev_done);
  assign w_is_err = (bus.sc_data == SC_ERR0) || (bus.sc_data == SC_ERR1);
  assign w_fake   = (bus.sc_data == SC_LSHIFT) || (bus.sc_data == SC_RSHIFT);
  assign w_drop   = (bus.sc_data == SC_BAT) || (bus.sc_data == SC_ACK) ||
                    (bus.sc_data == SC_RESEND) || (bus.sc_data == SC_ECHO);
  assign w_mask   = mod_mask(w_code, w_ext);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_err       = 1'b0;
    w_ext       = 1'b0;
    w_brk       = 1'b0;
    w_code      = bus.sc_data;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.sc_data == SC_EXT)            w_state_nxt = ST_EXT;
          else if (bus.sc_data == SC_BRK)       w_state_nxt = ST_BRK;
          else if (bus.sc_data == SC_PAUSE_PFX) begin
            w_state_nxt = ST_SKIP;
            w_cnt_nxt   = CW'(PAUSE_SKIP);
          end
          else if (w_is_err)                    w_err  = 1'b1;
          else if (!w_drop)                     w_emit = 1'b1;
        end
        ST_EXT: begin
          w_state_nxt = ST_IDLE;
          if (bus.sc_data == SC_BRK) w_state_nxt = ST_EXTBRK;
          else if (w_is_err)         w_err = 1'b1;
          else if (!w_fake) begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
          end
        end
        ST_BRK: begin
          w_state_nxt = ST_IDLE;
          if (w_is_err) w_err = 1'b1;
          else begin
            w_emit = 1'b1;
            w_brk  = 1'b1;
          end
        end
        ST_EXTBRK: begin
          w_state_nxt = ST_IDLE;
          if (!w_fake) begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
            w_brk  = 1'b1;
          end
        end
        ST_SKIP: begin
          w_cnt_nxt = r_cnt - CW'(1);
          // The whole Pause sequence collapses into one extended make of 77.
          if (r_cnt <= CW'(1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
            w_emit      = 1'b1;
            w_ext       = 1'b1;
            w_code      = SC_PAUSE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ev_rdy    <= 1'b0;
      r_ev_code   <= '0;
      r_ev_brk    <= 1'b0;
      r_ev_ext    <= 1'b0;
      r_mods      <= '0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err;
      if (w_emit) begin
        r_ev_rdy  <= 1'b1;
        r_ev_code <= w_code;
        r_ev_brk  <= w_brk;
        r_ev_ext  <= w_ext;
        r_mods    <= w_brk ? (r_mods & ~w_mask) : (r_mods | w_mask);
        // caps_held suppresses toggling on typematic repeats.
        if (!w_ext && w_code == SC_CAPS) begin
          if (w_brk)              r_caps_held <= 1'b0;
          else if (!r_caps_held) begin
            r_caps      <= ~r_caps;
            r_caps_held <= 1'b1;
          end
        end
      end else if (r_ev_rdy && bus.ev_done) begin
        r_ev_rdy <= 1'b0;
      end
    end
  end

  assign bus.sc_done = w_accept;
  assign bus.ev_rdy  = r_ev_rdy;
  assign bus.ev_code = r_ev_code;
  assign bus.ev_brk  = r_ev_brk;
  assign bus.ev_ext  = r_ev_ext;
  assign bus.mods    = r_mods;
  assign bus.caps    = r_caps;
  assign bus.err     = r_err;

endmodule
